// File: rtl/credit_reg_arbiter.sv
// credit_reg_arbiter: shares one register extern port between two valid-only requesters with per-requester queues and in-order response routing.
module credit_reg_arbiter #(
  parameter int QDEPTH = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int REQ_W = 65,
  parameter int RESP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [REQ_W-1:0]  req0_bits,
  output logic              resp0_valid,
  output logic [RESP_W-1:0] resp0_bits_new_val,
  input  logic              req1_valid,
  input  logic [REQ_W-1:0]  req1_bits,
  output logic              resp1_valid,
  output logic [RESP_W-1:0] resp1_bits_new_val,
  output logic              creditReg_req_valid,
  output logic [REQ_W-1:0]  creditReg_req_bits,
  input  logic              creditReg_resp_valid,
  input  logic [RESP_W-1:0] creditReg_resp_bits_new_val,
  output logic [15:0]       drop_cnt0,
  output logic [15:0]       drop_cnt1,
  output logic              err_overflow,
  output logic              err_spurious_resp
);
  localparam int QA = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam int TA = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  logic [REQ_W-1:0] qmem [2][QDEPTH];
  logic [QA-1:0] wp [2];
  logic [QA-1:0] rp [2];
  logic [QA:0] cnt [2];
  logic [15:0] dcnt [2];
  logic tag_mem [2**TA];
  logic [TA-1:0] twp, trp;
  logic [TA:0] tcnt;
  logic rr_last, gnt, gid, rsp_pop, head;
  logic [1:0] req_v, ne, full, pop, push, drop;
  logic [REQ_W-1:0] req_b [2];
  assign drop_cnt0 = dcnt[0];
  assign drop_cnt1 = dcnt[1];
  always_comb begin
    req_v = {req1_valid, req0_valid};
    req_b[0] = req0_bits;
    req_b[1] = req1_bits;
    ne = {cnt[1] != '0, cnt[0] != '0};
    full = {cnt[1] == (QA+1)'(QDEPTH), cnt[0] == (QA+1)'(QDEPTH)};
    gnt = (tcnt != (TA+1)'(MAX_OUTSTANDING)) && (|ne);
    gid = (&ne) ? ~rr_last : ne[1];
    pop = gnt ? (gid ? 2'b10 : 2'b01) : 2'b00;
    // a pop of a full queue frees the slot for a same-cycle arrival
    push = req_v & (~full | pop);
    drop = req_v & ~push;
    rsp_pop = creditReg_resp_valid && (tcnt != '0);
    head = tag_mem[trp];
  end
  always_ff @(posedge clock) begin
    for (int n = 0; n < 2; n++)
      if (push[n]) qmem[n][wp[n]] <= req_b[n];
    if (gnt) tag_mem[twp] <= gid;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        wp[n] <= '0;
        rp[n] <= '0;
        cnt[n] <= '0;
        dcnt[n] <= '0;
      end
      twp <= '0;
      trp <= '0;
      tcnt <= '0;
      rr_last <= 1'b1;
      creditReg_req_valid <= 1'b0;
      creditReg_req_bits <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_bits_new_val <= '0;
      resp1_bits_new_val <= '0;
      err_overflow <= 1'b0;
      err_spurious_resp <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        wp[n] <= wp[n] + QA'(push[n]);
        rp[n] <= rp[n] + QA'(pop[n]);
        cnt[n] <= cnt[n] + (QA+1)'(push[n]) - (QA+1)'(pop[n]);
        if (drop[n] && dcnt[n] != 16'hFFFF) dcnt[n] <= dcnt[n] + 16'd1;
      end
      creditReg_req_valid <= gnt;
      if (gnt) begin
        creditReg_req_bits <= qmem[gid][rp[gid]];
        rr_last <= gid;
      end
      twp <= twp + TA'(gnt);
      trp <= trp + TA'(rsp_pop);
      tcnt <= tcnt + (TA+1)'(gnt) - (TA+1)'(rsp_pop);
      resp0_valid <= rsp_pop && !head;
      resp1_valid <= rsp_pop && head;
      if (rsp_pop && !head) resp0_bits_new_val <= creditReg_resp_bits_new_val;
      if (rsp_pop && head) resp1_bits_new_val <= creditReg_resp_bits_new_val;
      err_overflow <= err_overflow | (|drop);
      err_spurious_resp <= err_spurious_resp | (creditReg_resp_valid && tcnt == '0);
    end
  end
endmodule

// File: tb/tb_credit_reg_arbiter.sv
// tb_credit_reg_arbiter: queue-based reference model feeding a scoreboard checked by an independent monitor.
module tb_credit_reg_arbiter;
  localparam int QD = 4;
  localparam int MAXO = 2;
  typedef struct { int cyc; logic [64:0] b; } exp_t;
  logic clock, reset;
  logic req0_valid, req1_valid, creditReg_req_valid, creditReg_resp_valid;
  logic [64:0] req0_bits, req1_bits, creditReg_req_bits;
  logic resp0_valid, resp1_valid, err_overflow, err_spurious_resp;
  logic [15:0] resp0_bits_new_val, resp1_bits_new_val, creditReg_resp_bits_new_val;
  logic [15:0] drop_cnt0, drop_cnt1;
  credit_reg_arbiter #(.QDEPTH(QD), .MAX_OUTSTANDING(MAXO), .REQ_W(65), .RESP_W(16)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_bits(req0_bits),
    .resp0_valid(resp0_valid), .resp0_bits_new_val(resp0_bits_new_val),
    .req1_valid(req1_valid), .req1_bits(req1_bits),
    .resp1_valid(resp1_valid), .resp1_bits_new_val(resp1_bits_new_val),
    .creditReg_req_valid(creditReg_req_valid), .creditReg_req_bits(creditReg_req_bits),
    .creditReg_resp_valid(creditReg_resp_valid), .creditReg_resp_bits_new_val(creditReg_resp_bits_new_val),
    .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1),
    .err_overflow(err_overflow), .err_spurious_resp(err_spurious_resp)
  );
  exp_t expq [3][$];
  logic [64:0] mq [2][$];
  bit m_tags [$];
  bit m_rr = 1'b1, m_eo, m_es, m_id;
  logic [15:0] md [2] = '{16'd0, 16'd0};
  logic [15:0] m_respb [2] = '{16'd0, 16'd0};
  logic [64:0] m_rb = '0;
  int m_ts;
  exp_t m_e, m_f;
  int cyc, n_vec, n_err;
  logic [2:0] mv;
  logic [64:0] mb [3];
  logic [130:0] st_got, st_exp;
  string nm [3] = '{"issue", "resp0", "resp1"};
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // reference model: requester queues, FIFO of outstanding ids, round-robin pointer
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      mq[0].delete();
      mq[1].delete();
      m_tags.delete();
      m_rr = 1'b1;
      md[0] = '0;
      md[1] = '0;
      m_eo = 1'b0;
      m_es = 1'b0;
      m_rb = '0;
      m_respb[0] = '0;
      m_respb[1] = '0;
    end else begin
      m_ts = m_tags.size();
      if (creditReg_resp_valid) begin
        if (m_ts == 0) m_es = 1'b1;
        else begin
          m_id = m_tags.pop_front();
          m_respb[m_id] = creditReg_resp_bits_new_val;
          m_e.cyc = cyc;
          m_e.b = 65'(creditReg_resp_bits_new_val);
          expq[m_id ? 2 : 1].push_back(m_e);
        end
      end
      if (m_ts < MAXO && (mq[0].size() > 0 || mq[1].size() > 0)) begin
        m_id = (mq[0].size() > 0 && mq[1].size() > 0) ? !m_rr : (mq[0].size() == 0);
        m_rb = mq[m_id].pop_front();
        m_e.cyc = cyc;
        m_e.b = m_rb;
        expq[0].push_back(m_e);
        m_tags.push_back(m_id);
        m_rr = m_id;
      end
      for (int n = 0; n < 2; n++)
        if (n == 0 ? req0_valid : req1_valid) begin
          if (mq[n].size() < QD) mq[n].push_back(n == 0 ? req0_bits : req1_bits);
          else begin
            if (md[n] != 16'hFFFF) md[n] = md[n] + 16'd1;
            m_eo = 1'b1;
          end
        end
    end
  end
  always @(negedge clock) begin
    mv = {resp1_valid, resp0_valid, creditReg_req_valid};
    mb[0] = creditReg_req_bits;
    mb[1] = 65'(resp0_bits_new_val);
    mb[2] = 65'(resp1_bits_new_val);
    for (int k = 0; k < 3; k++) begin
      if (mv[k]) begin
        n_vec++;
        if (expq[k].size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected: got %h at cycle %0d, required no pulse", nm[k], mb[k], cyc);
        end else begin
          m_f = expq[k].pop_front();
          if (m_f.cyc != cyc || m_f.b != mb[k]) begin
            n_err++;
            $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d", nm[k], mb[k], cyc, m_f.b, m_f.cyc);
          end
        end
      end else if (expq[k].size() > 0 && expq[k][0].cyc <= cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s missing: got no pulse at cycle %0d, required %h", nm[k], cyc, expq[k][0].b);
        void'(expq[k].pop_front());
      end
    end
    st_got = {drop_cnt0, drop_cnt1, err_overflow, err_spurious_resp, creditReg_req_bits, resp0_bits_new_val, resp1_bits_new_val};
    st_exp = {md[0], md[1], m_eo, m_es, m_rb, m_respb[0], m_respb[1]};
    n_vec++;
    if (st_got !== st_exp) begin
      n_err++;
      $display("FAIL status at cycle %0d: got %h, required %h", cyc, st_got, st_exp);
    end
  end
  function automatic logic [64:0] rnd();
    return {$urandom(), $urandom(), 1'($urandom())};
  endfunction
  task automatic drive(input bit v0, input logic [64:0] b0, input bit v1, input logic [64:0] b1,
                       input bit rv, input logic [15:0] rd);
    @(negedge clock);
    req0_valid = v0;
    req0_bits = b0;
    req1_valid = v1;
    req1_bits = b1;
    creditReg_resp_valid = rv;
    creditReg_resp_bits_new_val = rd;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, rnd(), 0, rnd(), 0, 16'($urandom()));
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((m_tags.size() > 0 || mq[0].size() > 0 || mq[1].size() > 0) && t < 300) begin
      drive(0, rnd(), 0, rnd(), m_tags.size() > 0, 16'($urandom()));
      t++;
    end
    if (t >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL drain timeout: got %0d outstanding after %0d cycles, required 0", m_tags.size(), t);
    end
    idle(3);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    creditReg_resp_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    req0_valid = 0;
    req1_valid = 0;
    req0_bits = '0;
    req1_bits = '0;
    creditReg_resp_valid = 0;
    creditReg_resp_bits_new_val = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(3);
    drive(1, {16'h0005, 48'h0, 1'b1}, 0, rnd(), 0, 16'h0);
    idle(4);
    drive(0, rnd(), 0, rnd(), 1, 16'h0042);
    idle(4);
    repeat (4) drive(1, rnd(), 1, rnd(), 0, 16'h0);
    drain();
    repeat (8) drive(1, rnd(), 0, rnd(), 0, 16'h0);
    idle(3);
    drain();
    drive(0, rnd(), 0, rnd(), 1, 16'h1234);
    idle(3);
    repeat (3) drive(1, rnd(), 1, rnd(), 0, 16'h0);
    drive(0, rnd(), 0, rnd(), 1, 16'h00AA);
    drain();
    repeat (1500)
      drive($urandom_range(0, 99) < 40, rnd(), $urandom_range(0, 99) < 40, rnd(),
            $urandom_range(0, 99) < 45, 16'($urandom()));
    drain();
    repeat (3) drive(1, rnd(), 1, rnd(), 0, 16'h0);
    do_reset();
    repeat (3) drive(0, rnd(), 0, rnd(), 1, 16'($urandom()));
    idle(10);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (expq[k].size() != 0) begin
        n_err++;
        $display("FAIL %s leftover: got %0d pending, required 0", nm[k], expq[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/credit_reg_arbiter.md
Name: credit_reg_arbiter

Overview:
- Shares the single credit ifElseRaw register extern port (creditReg req/resp) between two SDNet pipelines: requester 0 = NDP ingress, requester 1 = NDP egress.
- SDNet extern requests are valid-only pulses with no ready, so the block buffers each requester's requests, round-robins them onto the shared port, and tracks outstanding requests by tag.
- Routes each in-order response back to the requester that issued it.

Parameters:
QDEPTH, 4, per-requester request queue depth (power of 2, >=2)
MAX_OUTSTANDING, 8, max issued-but-unanswered requests (power of 2)
REQ_W, 65, request bits width: {index[15:0], data_1[15:0], opCode_1[7:0], data_0[15:0], opCode_0[7:0], predicate}
RESP_W, 16, response new_val width

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
req0_valid  in  1  requester 0 request pulse
req0_bits  in  REQ_W  requester 0 request
resp0_valid  out  1  response to requester 0
resp0_bits_new_val  out  RESP_W  response data to requester 0
req1_valid  in  1  requester 1 request pulse
req1_bits  in  REQ_W  requester 1 request
resp1_valid  out  1  response to requester 1
resp1_bits_new_val  out  RESP_W  response data to requester 1
creditReg_req_valid  out  1  request to shared register extern
creditReg_req_bits  out  REQ_W  request to shared register extern
creditReg_resp_valid  in  1  response from register extern (in order)
creditReg_resp_bits_new_val  in  RESP_W  response data
drop_cnt0  out  16  requester 0 dropped-request count, saturating
drop_cnt1  out  16  requester 1 dropped-request count, saturating
err_overflow  out  1  sticky: some request dropped
err_spurious_resp  out  1  sticky: response arrived with no outstanding tag

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0; queues and tag FIFO empty; rr_last = 1, so requester 0 wins the first tie.
- Enqueue:
  - reqN_valid at edge E with queue N not full -> written at E.
  - Queue full -> request dropped, drop_cntN += 1 (saturates at 0xFFFF), err_overflow set.
  - A request arriving in the same cycle as a pop of a full queue is accepted; the pop frees space first.
- Issue:
  - Each cycle, grant one non-empty queue if the tag FIFO is not full.
  - Both non-empty -> grant the one != rr_last; rr_last <= granted id.
  - Grant loads registered outputs creditReg_req_valid/bits and pushes the granted id into the tag FIFO.
  - No grant -> creditReg_req_valid = 0 next cycle; bits hold their last value.
  - Minimum latency: request sampled at edge E, visible on creditReg_req at cycle E+2.
  - Throughput: 1 request/cycle aggregate.
- Tag FIFO full (MAX_OUTSTANDING outstanding) -> issue stalls and queues keep filling. Issue resumes in the cycle after a response frees a slot; a pop and a push in the same cycle are allowed.
- Response:
  - creditReg_resp_valid pops the tag FIFO head id.
  - Next cycle, respN_valid = 1 for that id with the registered new_val; the other requester's resp_valid = 0.
  - resp_valid with the tag FIFO empty -> dropped, err_spurious_resp set.
- Pointer wrap: queue and tag FIFO pointers wrap modulo depth; full/empty are distinguished by an extra pointer bit or a count.
- Reset mid-operation:
  - All queued and outstanding state is discarded.
  - Responses returning after reset for pre-reset requests are treated as spurious.
- Sticky flags and counters clear only on reset.

Test Plan:
- Single req0 (index=0x0005, predicate=1) at cycle 10 -> creditReg_req_valid at cycle 12 with identical bits. resp new_val=0x0042 at cycle 15 -> resp0_valid at cycle 16 with 0x0042; resp1_valid stays 0.
- req0 and req1 pulse together every cycle for 4 cycles, resp returned 3 cycles after each issue -> issue order 0,1,0,1,0,1,0,1 with strict alternation; responses routed in matching order; no drops.
- req0 pulses 6 cycles back-to-back while the register never responds (MAX_OUTSTANDING=2, QDEPTH=4):
  - Exactly 2 issued, 4 queued; drop_cnt0 = 0.
  - A 7th and 8th pulse -> drop_cnt0 = 2, err_overflow = 1.
  - Then 2 responses -> 2 more issues follow.
- creditReg_resp_valid with nothing outstanding -> no resp0/resp1 pulse; err_spurious_resp = 1.
- Response pop and a new issue in the same cycle with the tag FIFO full -> the issue proceeds the following cycle and the outstanding count stays at MAX_OUTSTANDING.
- Reset asserted with 3 outstanding and 2 queued:
  - All outputs 0 the cycle after reset.
  - No stale requests are issued afterwards.
  - Returning old responses set err_spurious_resp.
